// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, packer state encoding and padding helpers.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  // Lanes n..15 take the PKCS#7 pad value (16-n); n=16 leaves the block untouched.
  function automatic aes_block_t pkcs7_fill(aes_block_t block, logic [4:0] n);
    aes_block_t res;
    logic [7:0] pad;
    res = block;
    pad = 8'(AES_BLOCK_BYTES - int'(n));
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (i >= int'(n)) res[8*(AES_BLOCK_BYTES-1-i) +: 8] = pad;
    end
    return res;
  endfunction

  // Lanes n..15 take a fixed byte value.
  function automatic aes_block_t lane_fill(aes_block_t block, logic [4:0] n, logic [7:0] fill);
    aes_block_t res;
    res = block;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (i >= int'(n)) res[8*(AES_BLOCK_BYTES-1-i) +: 8] = fill;
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Byte stream to 128-bit AES block packer with end-of-message padding.
// Build option PKCS7_PAD_EN: PKCS#7 padding (incl. extra 0x10 block); otherwise FILL_BYTE fill.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [127:0]  m_block,
  output logic          m_last,
  output logic [4:0]    m_nbytes,
  output packer_state_t dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // m_valid and the block fields hold steady until that edge.

  packer_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  aes_block_t    blk_q, blk_d;
  logic          last_q, last_d;
  logic [4:0]    nbytes_q, nbytes_d;
`ifdef PKCS7_PAD_EN
  logic          pad_pending_q, pad_pending_d;
`endif

  aes_block_t blk_byte;
  logic [4:0] cnt_inc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    last_d   = last_q;
    nbytes_d = nbytes_q;
`ifdef PKCS7_PAD_EN
    pad_pending_d = pad_pending_q;
`endif
    cnt_inc  = cnt_q + 5'd1;
    blk_byte = blk_q;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (cnt_q[3:0] == 4'(i)) blk_byte[8*(AES_BLOCK_BYTES-1-i) +: 8] = s_data;
    end

    case (state_q)
      FILL: begin
        if (s_valid) begin
          blk_d = blk_byte;
          cnt_d = cnt_inc;
          if (s_last) begin
            state_d  = HOLD;
            nbytes_d = cnt_inc;
`ifdef PKCS7_PAD_EN
            blk_d = pkcs7_fill(blk_byte, cnt_inc);
            // A full final block needs a separate all-0x10 pad block after it.
            if (cnt_inc == 5'd16) begin
              last_d        = 1'b0;
              pad_pending_d = 1'b1;
            end else begin
              last_d = 1'b1;
            end
`else
            blk_d  = lane_fill(blk_byte, cnt_inc, FILL_BYTE);
            last_d = 1'b1;
`endif
          end else if (cnt_inc == 5'd16) begin
            state_d  = HOLD;
            nbytes_d = 5'd16;
            last_d   = 1'b0;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
`ifdef PKCS7_PAD_EN
          if (pad_pending_q) begin
            blk_d         = {AES_BLOCK_BYTES{8'h10}};
            nbytes_d      = 5'd0;
            last_d        = 1'b1;
            pad_pending_d = 1'b0;
          end else begin
            state_d  = FILL;
            cnt_d    = 5'd0;
            last_d   = 1'b0;
            nbytes_d = 5'd0;
          end
`else
          state_d  = FILL;
          cnt_d    = 5'd0;
          last_d   = 1'b0;
          nbytes_d = 5'd0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FILL;
      cnt_q    <= 5'd0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      nbytes_q <= 5'd0;
`ifdef PKCS7_PAD_EN
      pad_pending_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      last_q   <= last_d;
      nbytes_q <= nbytes_d;
`ifdef PKCS7_PAD_EN
      pad_pending_q <= pad_pending_d;
`endif
    end
  end

  assign s_ready   = (state_q == FILL);
  assign m_valid   = (state_q == HOLD);
  assign m_block   = blk_q;
  assign m_last    = last_q;
  assign m_nbytes  = nbytes_q;
  assign dbg_state = state_q;

endmodule
